// File: rtl/sw_array_ctrl_if.sv
// Bus between the Smith-Waterman chain sequencer and its environment:
// job control, read/reference streams, PE-facing strobes and tail score feedback.
interface sw_array_ctrl_if #(
  parameter int NUM_PE      = 8,
  parameter int SCORE_WIDTH = 10,
  parameter int LEN_WIDTH   = 16
);
  logic                   start;
  logic [LEN_WIDTH-1:0]   ref_len;
  logic [1:0]             rd_base;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [1:0]             ref_base;
  logic                   ref_valid;
  logic                   ref_ready;
  logic [1:0]             pe_S;
  logic [NUM_PE-1:0]      pe_store_S;
  logic [1:0]             pe_T;
  logic                   pe_init;
  logic [SCORE_WIDTH-1:0] tail_V;
  logic                   tail_init;
  logic                   busy;
  logic                   done;
  logic [SCORE_WIDTH-1:0] best_score;
  logic [LEN_WIDTH-1:0]   best_col;

  modport slave (
    input  start, ref_len, rd_base, rd_valid, ref_base, ref_valid, tail_V, tail_init,
    output rd_ready, ref_ready, pe_S, pe_store_S, pe_T, pe_init, busy, done,
           best_score, best_col
  );

  modport master (
    output start, ref_len, rd_base, rd_valid, ref_base, ref_valid, tail_V, tail_init,
    input  rd_ready, ref_ready, pe_S, pe_store_S, pe_T, pe_init, busy, done,
           best_score, best_col
  );
endinterface

// File: rtl/sw_array_ctrl.sv
// Sequencer for a linear Smith-Waterman PE chain: loads the read, streams the
// reference, waits for the chain to drain and reports the best tail score/column.
module sw_array_ctrl #(
  parameter int NUM_PE      = 8,
  parameter int SCORE_WIDTH = 10,
  parameter int LEN_WIDTH   = 16
) (
  input  logic             clk,
  input  logic             rst,
  sw_array_ctrl_if.slave   ctrl
);

  localparam int LCW = $clog2(NUM_PE + 1);
  localparam int DCW = $clog2(2 * NUM_PE + 2);
  localparam logic [LCW-1:0] LOAD_LAST  = LCW'(NUM_PE - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2 * NUM_PE);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MIN = {1'b1, {(SCORE_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_FIN} state_e;

  state_e                 state_q, state_d;
  logic [LCW-1:0]         load_cnt_q, load_cnt_d;
  logic [LEN_WIDTH-1:0]   ref_cnt_q, ref_cnt_d;
  logic [DCW-1:0]         drain_cnt_q, drain_cnt_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   tail_col_q, tail_col_d;
  logic [SCORE_WIDTH-1:0] best_score_q, best_score_d;
  logic [LEN_WIDTH-1:0]   best_col_q, best_col_d;
  logic [1:0]             pe_S_q, pe_S_d;
  logic [NUM_PE-1:0]      pe_store_S_q, pe_store_S_d;
  logic [1:0]             pe_T_q, pe_T_d;
  logic                   pe_init_q, pe_init_d;
  logic [NUM_PE-1:0]      store_onehot;

  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_onehot
    assign store_onehot[gi] = (load_cnt_q == LCW'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      load_cnt_q   <= '0;
      ref_cnt_q    <= '0;
      drain_cnt_q  <= '0;
      len_q        <= '0;
      tail_col_q   <= '0;
      best_score_q <= '0;
      best_col_q   <= '0;
      pe_S_q       <= '0;
      pe_store_S_q <= '0;
      pe_T_q       <= '0;
      pe_init_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      ref_cnt_q    <= ref_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      len_q        <= len_d;
      tail_col_q   <= tail_col_d;
      best_score_q <= best_score_d;
      best_col_q   <= best_col_d;
      pe_S_q       <= pe_S_d;
      pe_store_S_q <= pe_store_S_d;
      pe_T_q       <= pe_T_d;
      pe_init_q    <= pe_init_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    ref_cnt_d    = ref_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    len_d        = len_q;
    tail_col_d   = tail_col_q;
    best_score_d = best_score_q;
    best_col_d   = best_col_q;
    pe_S_d       = pe_S_q;
    pe_store_S_d = '0;
    pe_T_d       = pe_T_q;
    pe_init_d    = 1'b0;

    // Tail monitoring runs in every state; a start in IDLE overrides it below.
    if (ctrl.tail_init) begin
      if ($signed(ctrl.tail_V) > $signed(best_score_q)) begin
        best_score_d = ctrl.tail_V;
        best_col_d   = tail_col_q;
      end
      if (tail_col_q != '1) begin
        tail_col_d = tail_col_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (ctrl.start) begin
          len_d        = ctrl.ref_len;
          best_score_d = SCORE_MIN;
          best_col_d   = '0;
          tail_col_d   = '0;
          load_cnt_d   = '0;
          ref_cnt_d    = '0;
          state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ctrl.rd_valid) begin
          pe_S_d       = ctrl.rd_base;
          pe_store_S_d = store_onehot;
          if (load_cnt_q == LOAD_LAST) begin
            load_cnt_d  = '0;
            drain_cnt_d = '0;
            state_d     = (len_q == '0) ? S_DRAIN : S_STREAM;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (ctrl.ref_valid) begin
          pe_T_d    = ctrl.ref_base;
          pe_init_d = 1'b1;
          // Counting to len-1 keeps the counter in range for the largest ref_len.
          if (ref_cnt_q == len_q - 1'b1) begin
            ref_cnt_d   = '0;
            drain_cnt_d = '0;
            state_d     = S_DRAIN;
          end else begin
            ref_cnt_d = ref_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = S_FIN;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ctrl.rd_ready   = (state_q == S_LOAD);
  assign ctrl.ref_ready  = (state_q == S_STREAM);
  assign ctrl.busy       = (state_q != S_IDLE);
  assign ctrl.done       = (state_q == S_FIN);
  assign ctrl.pe_S       = pe_S_q;
  assign ctrl.pe_store_S = pe_store_S_q;
  assign ctrl.pe_T       = pe_T_q;
  assign ctrl.pe_init    = pe_init_q;
  assign ctrl.best_score = best_score_q;
  assign ctrl.best_col   = best_col_q;

endmodule
